// File: rtl/i2c_cmd_sequencer.sv
// Queues host I2C commands and runs them one at a time on the master, one response per command.
// Latency: pop one edge after a push into an empty queue; response one edge after the master returns idle.
// Backpressure: cmd_ready drops when the queue is full; a held response stalls the next issue.

module i2c_cmd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic                     pop_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Fullness is judged before any same-cycle pop, so a full queue never takes a push.
  assign do_push = push_vld && !full;
  assign do_pop  = pop_vld && !empty;
  assign rd_dat  = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr_dat;
  end
endmodule

module i2c_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [6:0]             cmd_addr,
  input  logic                   cmd_rw,
  input  logic [7:0]             cmd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_data,
  output logic                   rsp_err,
  output logic [6:0]             m_addr,
  output logic [7:0]             m_data_in,
  output logic                   m_rw,
  output logic                   m_enable,
  input  logic [7:0]             m_data_out,
  input  logic                   m_ready,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;
  logic [15:0]   head_dat;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;

  i2c_cmd_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (cmd_valid),
    .pop_vld  (fifo_pop),
    .wr_dat   ({cmd_rw, cmd_addr, cmd_data}),
    .rd_dat   (head_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE);
  assign fifo_pop  = (state == IDLE) && m_ready && !fifo_empty;
  assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      m_addr    <= '0;
      m_data_in <= '0;
      m_rw      <= 1'b0;
      m_enable  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            {m_rw, m_addr, m_data_in} <= head_dat;
            timer    <= '0;
            m_enable <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (!m_ready) begin
            m_enable <= 1'b0;
            timer    <= '0;
            state    <= WAIT_DONE;
          end else if (timer == T_LAST) begin
            m_enable  <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            timer <= timer_inc;
          end
        end
        WAIT_DONE: begin
          if (m_ready) begin
            rsp_data  <= m_rw ? m_data_out : 8'h00;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (timer == T_LAST) begin
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            timer <= timer_inc;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a simple I2C master model.
module tb_i2c_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int MDL_NORMAL = 0;
  localparam int MDL_HOLD_LOW = 1;
  localparam int MDL_STUCK_HIGH = 2;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [6:0] m_addr;
  logic [7:0] m_data_in;
  logic       m_rw;
  logic       m_enable;
  logic [7:0] m_data_out = 8'h00;
  logic       m_ready = 1'b1;
  logic       busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int mdl_mode = MDL_NORMAL;
  int mdl_cnt = 0;

  i2c_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rw(cmd_rw), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_rw(m_rw), .m_enable(m_enable),
    .m_data_out(m_data_out), .m_ready(m_ready),
    .busy(busy), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Master model: ready drops 3 cycles after enable, stays low 40 cycles; reads return addr+0x0C.
  always begin
    @(posedge clk);
    #3;
    if (mdl_mode == MDL_STUCK_HIGH) begin
      m_ready = 1'b1;
      mdl_cnt = 0;
    end else if (mdl_mode == MDL_HOLD_LOW) begin
      m_ready = 1'b0;
      mdl_cnt = 0;
    end else if (mdl_cnt == 0) begin
      if (m_enable) mdl_cnt = 1;
      else m_ready = 1'b1;
    end else begin
      mdl_cnt = mdl_cnt + 1;
      if (mdl_cnt == 3) m_ready = 1'b0;
      else if (mdl_cnt == 43) begin
        m_ready = 1'b1;
        m_data_out = m_rw ? ({1'b0, m_addr} + 8'h0C) : 8'hEE;
        mdl_cnt = 0;
      end
    end
  end

  task automatic push(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_data = data;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_accept: cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input logic [7:0] exp_d, input logic exp_e, input string name);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: rsp_valid=%b required 1 (timed out)", name, rsp_valid);
    end else if (rsp_data !== exp_d || rsp_err !== exp_e) begin
      errors++;
      $display("FAIL %s: data=%h err=%b required data=%h err=%b", name, rsp_data, rsp_err, exp_d, exp_e);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_err !== 1'b0 ||
        m_enable !== 1'b0 || m_addr !== 7'h00 || m_data_in !== 8'h00 || m_rw !== 1'b0 ||
        busy !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b rv=%b rd=%h re=%b en=%b ma=%h md=%h rw=%b busy=%b cnt=%0d required 1 0 00 0 0 00 00 0 0 0",
               cmd_ready, rsp_valid, rsp_data, rsp_err, m_enable, m_addr, m_data_in, m_rw, busy, fifo_count);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write;
    int n;
    push(1'b0, 7'h2A, 8'hAA);
    checks++;
    if (fifo_count !== 3'd1 || m_enable !== 1'b0) begin
      errors++;
      $display("FAIL start_push: cnt=%0d en=%b required 1 0", fifo_count, m_enable);
    end
    @(negedge clk);
    checks++;
    if (m_enable !== 1'b1 || busy !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL start_pop: en=%b busy=%b cnt=%0d required 1 1 0", m_enable, busy, fifo_count);
    end
    checks++;
    if (m_addr !== 7'h2A || m_data_in !== 8'hAA || m_rw !== 1'b0) begin
      errors++;
      $display("FAIL write_drive: addr=%h data=%h rw=%b required 2a aa 0", m_addr, m_data_in, m_rw);
    end
    n = 0;
    while (m_ready !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (m_enable !== 1'b1 || m_ready !== 1'b0) begin
      errors++;
      $display("FAIL enable_hold: en=%b ready=%b required 1 0", m_enable, m_ready);
    end
    @(negedge clk);
    checks++;
    if (m_enable !== 1'b0) begin
      errors++;
      $display("FAIL enable_release: en=%b required 0", m_enable);
    end
    get_rsp(8'h00, 1'b0, "write_rsp");
  endtask

  task automatic test_single_read;
    push(1'b1, 7'h50, 8'h00);
    get_rsp(8'h5C, 1'b0, "read_rsp");
  endtask

  task automatic test_back_to_back;
    push(1'b1, 7'h60, 8'h00);
    push(1'b0, 7'h61, 8'h77);
    while (rsp_valid !== 1'b1 && mdl_cnt < 1000) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h6C || m_enable !== 1'b0 || fifo_count !== 3'd1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rv=%b data=%h en=%b cnt=%0d required 1 6c 0 1",
                 i, rsp_valid, rsp_data, m_enable, fifo_count);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || m_enable !== 1'b0 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL bp_handshake: rv=%b busy=%b en=%b cnt=%0d required 0 0 0 1", rsp_valid, busy, m_enable, fifo_count);
    end
    @(negedge clk);
    checks++;
    if (m_enable !== 1'b1 || fifo_count !== 3'd0 || m_addr !== 7'h61 || m_data_in !== 8'h77) begin
      errors++;
      $display("FAIL bp_next_issue: en=%b cnt=%0d addr=%h data=%h required 1 0 61 77", m_enable, fifo_count, m_addr, m_data_in);
    end
    get_rsp(8'h00, 1'b0, "bp_second_rsp");
  endtask

  task automatic test_fill_order;
    int n;
    mdl_mode = MDL_HOLD_LOW;
    repeat (2) @(negedge clk);
    push(1'b1, 7'h10, 8'h00);
    push(1'b0, 7'h11, 8'h33);
    push(1'b1, 7'h20, 8'h00);
    push(1'b1, 7'h30, 8'h00);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 7'h40; cmd_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (fifo_count !== 3'd4 || cmd_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL fill_full[%0d]: cnt=%0d rdy=%b busy=%b required 4 0 0", i, fifo_count, cmd_ready, busy);
      end
    end
    mdl_mode = MDL_NORMAL;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b1 || fifo_count !== 3'd3 || cmd_ready !== 1'b1 || m_addr !== 7'h10) begin
      errors++;
      $display("FAIL fill_first_pop: busy=%b cnt=%0d rdy=%b addr=%h required 1 3 1 10", busy, fifo_count, cmd_ready, m_addr);
    end
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL fill_pending_push: cnt=%0d required 4", fifo_count);
    end
    cmd_valid = 1'b0;
    get_rsp(8'h1C, 1'b0, "order_0");
    get_rsp(8'h00, 1'b0, "order_1");
    get_rsp(8'h2C, 1'b0, "order_2");
    get_rsp(8'h3C, 1'b0, "order_3");
    get_rsp(8'h4C, 1'b0, "order_4");
  endtask

  task automatic test_issue_timeout;
    int drops;
    mdl_mode = MDL_STUCK_HIGH;
    repeat (2) @(negedge clk);
    push(1'b0, 7'h05, 8'h12);
    @(negedge clk);
    checks++;
    if (m_enable !== 1'b1) begin
      errors++;
      $display("FAIL timeout_start: en=%b required 1", m_enable);
    end
    drops = 0;
    for (int i = 0; i < 1022; i++) begin
      @(negedge clk);
      if (m_enable !== 1'b1 || rsp_valid !== 1'b0) drops++;
    end
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL timeout_early: early cycles=%0d required 0", drops);
    end
    @(negedge clk);
    checks++;
    if (m_enable !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL timeout_fire: en=%b rv=%b err=%b data=%h required 0 1 1 00", m_enable, rsp_valid, rsp_err, rsp_data);
    end
    get_rsp(8'h00, 1'b1, "timeout_rsp");
    mdl_mode = MDL_NORMAL;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    int stray;
    push(1'b1, 7'h01, 8'h00);
    push(1'b0, 7'h02, 8'h22);
    push(1'b1, 7'h03, 8'h00);
    n = 0;
    while ((m_ready !== 1'b0 || m_enable !== 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || fifo_count !== 3'd2 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pre: busy=%b cnt=%0d rv=%b required 1 2 0", busy, fifo_count, rsp_valid);
    end
    rst = 1'b0;
    mdl_mode = MDL_STUCK_HIGH;
    #1;
    checks++;
    if (m_enable !== 1'b0 || fifo_count !== 3'd0 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_now: en=%b cnt=%0d rv=%b busy=%b rdy=%b required 0 0 0 0 1",
               m_enable, fifo_count, rsp_valid, busy, cmd_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || m_enable !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL rst_mid_after: stray active cycles=%0d required 0", stray);
    end
  endtask

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 7'h00; cmd_data = 8'h00;
    rsp_ready = 1'b0;
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_fill_order();
    test_issue_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
